// File: rtl/led_trail_fader_pkg.sv
// Shared constants and helpers for the LED comet-tail fader.
// Gamma table used when LED_TRAIL_GAMMA_EN is defined.
package led_trail_fader_pkg;

  localparam int DEFAULT_PWM_BITS   = 4;
  localparam int PWM_MAX            = (1 << DEFAULT_PWM_BITS) - 1;
  localparam int DEFAULT_DECAY_DIV  = 1250000;
  localparam int DEFAULT_DECAY_STEP = 3;

  // Counter width that stays at least one bit for a divide-by-one prescaler.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [3:0] gamma4(input logic [3:0] b);
    logic [3:0] g;
    case (b)
      4'd0, 4'd1, 4'd2: g = 4'd0;
      4'd3, 4'd4:       g = 4'd1;
      4'd5, 4'd6:       g = 4'd2;
      4'd7:             g = 4'd3;
      4'd8:             g = 4'd4;
      4'd9:             g = 4'd5;
      4'd10:            g = 4'd6;
      4'd11:            g = 4'd7;
      4'd12:            g = 4'd9;
      4'd13:            g = 4'd10;
      4'd14:            g = 4'd12;
      4'd15:            g = 4'd15;
      default:          g = 4'd0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/led_trail_fader_pwm_channel.sv
// One fader channel: brightness register with load/decay, optional gamma
// (LED_TRAIL_GAMMA_EN), PWM compare and registered LED drive.
module led_trail_fader_pwm_channel
  import led_trail_fader_pkg::*;
#(
  parameter int PWM_BITS   = DEFAULT_PWM_BITS,
  parameter int DECAY_STEP = DEFAULT_DECAY_STEP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable_i,
  input  logic                load_i,
  input  logic                tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o
);

  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [PWM_BITS-1:0] level_s;
  logic                led_q, led_d;

  // Load outranks decay; decay saturates at zero even for large steps.
  always_comb begin
    bright_d = bright_q;
    if (enable_i && load_i) begin
      bright_d = '1;
    end else if (enable_i && tick_i) begin
      if (int'(bright_q) > DECAY_STEP) begin
        bright_d = bright_q - PWM_BITS'(DECAY_STEP);
      end else begin
        bright_d = '0;
      end
    end else begin
      bright_d = bright_q;
    end
  end

`ifdef LED_TRAIL_GAMMA_EN
  if (PWM_BITS != 4) begin : g_bad_width
    $error("LED_TRAIL_GAMMA_EN requires PWM_BITS == 4");
  end
  // Gamma lookup sits ahead of the output flop, so latency is unchanged.
  always_comb begin
    level_s = gamma4(bright_q);
  end
`else
  // Linear brightness-to-duty mapping.
  always_comb begin
    level_s = bright_q;
  end
`endif

  // PWM compare against the shared counter.
  always_comb begin
    led_d = (level_s > pwm_cnt_i);
  end

  // Brightness and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bright_q <= '0;
      led_q    <= 1'b0;
    end else begin
      bright_q <= bright_d;
      led_q    <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_trail_fader.sv
// Comet-tail LED fader: shared decay prescaler, free-running PWM counter and
// N_LEDS fading channels. Optional gamma mapping via LED_TRAIL_GAMMA_EN.
module led_trail_fader
  import led_trail_fader_pkg::*;
#(
  parameter int N_LEDS     = 8,
  parameter int PWM_BITS   = DEFAULT_PWM_BITS,
  parameter int DECAY_DIV  = DEFAULT_DECAY_DIV,
  parameter int DECAY_STEP = DEFAULT_DECAY_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_LEDS-1:0] leds_in,
  output logic [N_LEDS-1:0] leds_out,
  output logic              tick
);

  localparam int PRE_W = cnt_width(DECAY_DIV);
  localparam int MAX   = (1 << PWM_BITS) - 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(MAX - 1);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic                tick_q, tick_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;

  // Prescaler advances only while enabled; tick flags its wrap one cycle later.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (enable) begin
      if (presc_q == PRE_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PRE_W'(1);
        tick_d  = 1'b0;
      end
    end else begin
      presc_d = presc_q;
      tick_d  = 1'b0;
    end
  end

  // PWM period is MAX clocks so that level MAX is constantly on.
  always_comb begin
    if (pwm_q == PWM_LAST) begin
      pwm_d = '0;
    end else begin
      pwm_d = pwm_q + PWM_BITS'(1);
    end
  end

  // Shared timing registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      pwm_q   <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      pwm_q   <= pwm_d;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_trail_fader_pwm_channel #(
      .PWM_BITS  (PWM_BITS),
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable_i (enable),
      .load_i   (leds_in[i]),
      .tick_i   (tick_q),
      .pwm_cnt_i(pwm_q),
      .led_o    (leds_out[i])
    );
  end

  assign tick = tick_q;

endmodule

// File: tb/tb_led_trail_fader.sv
// Self-checking bench for led_trail_fader (DECAY_DIV=4, DECAY_STEP=3).
module tb_led_trail_fader;

  localparam int DIV  = 4;
  localparam int STEP = 3;
  localparam int MAXB = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] leds_in = 8'h00;
  logic [7:0] leds_out;
  logic       tick;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  int         m_b [8];
  int         m_pwm;
  int         m_en_cnt;
  logic       m_tick;
  logic [7:0] m_out;

  led_trail_fader #(
    .N_LEDS(8), .PWM_BITS(4), .DECAY_DIV(DIV), .DECAY_STEP(STEP)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .leds_in(leds_in), .leds_out(leds_out), .tick(tick)
  );

  always #5 clk = ~clk;

  function automatic int lvl(input int b);
`ifdef LED_TRAIL_GAMMA_EN
    int g [16] = '{0, 0, 0, 1, 1, 2, 2, 3, 4, 5, 6, 7, 9, 10, 12, 15};
    return g[b];
`else
    return b;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: brightness per channel, tick from count of enabled edges.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        foreach (m_b[i]) m_b[i] = 0;
        m_pwm = 0; m_en_cnt = 0; m_tick = 1'b0; m_out = 8'h00;
      end else begin
        for (int i = 0; i < 8; i++) m_out[i] = (lvl(m_b[i]) > m_pwm);
        for (int i = 0; i < 8; i++) begin
          if (enable && leds_in[i]) m_b[i] = MAXB;
          else if (enable && m_tick) m_b[i] = (m_b[i] > STEP) ? m_b[i] - STEP : 0;
        end
        if (enable) begin
          m_en_cnt++;
          m_tick = (m_en_cnt % DIV == 0);
        end else begin
          m_tick = 1'b0;
        end
        m_pwm = (m_pwm + 1) % MAXB;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on && !reset) begin
        check("leds_out", int'(leds_out), int'(m_out));
        check("tick", int'(tick), int'(m_tick));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit [7];
    int highs, ticks, cnt, guard, lows, lit_on;
`ifdef LED_TRAIL_GAMMA_EN
    lit = '{15, 9, 5, 2, 1, 0, 0};
`else
    lit = '{15, 12, 9, 6, 3, 0, 0};
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_on = 1'b1;

    // Load latency: pin goes high two edges after the input.
    @(negedge clk); enable = 1'b1; leds_in = 8'h80;
    @(negedge clk); leds_in = 8'h00;
    check("lat_edge_t", int'(leds_out[7]), 0);
    @(negedge clk);
    check("lat_edge_t1", int'(leds_out[7]), 1);

    // Fade to k ticks, then freeze with all inputs asserted and measure duty.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); enable = 1'b1; leds_in = 8'hFF;
      @(negedge clk); leds_in = 8'h00;
      cnt = 0; guard = 0;
      if (k > 0) begin
        if (tick) cnt++;
        while (cnt < k && guard < 100) begin
          @(negedge clk); guard++;
          if (tick) cnt++;
        end
        if (guard >= 100) check("tick_timeout", cnt, k);
        @(negedge clk);
      end
      enable = 1'b0; leds_in = 8'hFF;
      highs = 0; ticks = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        highs += int'(leds_out[7]);
        ticks += int'(tick);
      end
      check($sformatf("freeze_duty_k%0d", k), highs, 2 * lit[k]);
      check($sformatf("freeze_tick_k%0d", k), ticks, 0);
      leds_in = 8'h00;
    end

    // Load held across tick cycles keeps the channel fully on.
    @(negedge clk); enable = 1'b1; leds_in = 8'h08;
    @(negedge clk);
    lows = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      lows += int'(!leds_out[3]);
    end
    check("priority_lows", lows, 0);

    // Asynchronous reset mid-fade darkens immediately; no tail afterwards.
    @(negedge clk); leds_in = 8'hFF;
    @(negedge clk); leds_in = 8'h00;
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("rst_leds", int'(leds_out), 0);
    check("rst_tick", int'(tick), 0);
    @(negedge clk); reset = 1'b0; enable = 1'b1;
    lit_on = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      lit_on += int'(|leds_out);
    end
    check("no_tail", lit_on, 0);

    // Randomised traffic with occasional mid-cycle resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      enable = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       leds_in = 8'(1 << $urandom_range(0, 7));
        1:       leds_in = 8'($urandom);
        default: leds_in = 8'h00;
      endcase
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
      end
    end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
